read_uart: RTL and testbench

- UART receive path; the receive-side counterpart of the team's UART transmitter. It deserialises one frame from the RxD line into a parallel byte.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit (XOR of the 8 data bits), 1 stop bit (1).
- Sits between the board UART pin and the crypto core's byte-input interface. Flags parity and framing errors, and flags an overrun when the consumer has not taken the previous byte.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rx_sync.sv | 28 ++
 rtl/read_uart.sv | 123 ++++++++++++
 tb/tb_read_uart.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART receive and transmit paths.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RxD pin plus a falling-edge detector.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic RxD,
  output logic rx_s,
  output logic fall
);

  logic meta;
  logic prev;

  // All flops reset to the idle line level so that reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= RxD;
      rx_s <= meta;
      prev <= rx_s;
    end
  end

  assign fall = prev & ~rx_s;

endmodule

// File: rtl/read_uart.sv
// UART receiver: start bit, 8 data bits LSB first, even parity, one stop bit.
module read_uart
  import uart_pkg::*;
#(
  parameter int freq = 347
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int half = (freq + 1) / 2;
  localparam int CW   = $clog2(freq + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(freq);
  localparam logic [CW-1:0] CNT_MID  = CW'(half - 1);
  localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

  uart_rx_state_t state;
  logic [CW-1:0]  cnt;
  logic [2:0]     idx;
  logic [7:0]     shift;
  logic           par_bit;
  logic           rx_s;
  logic           fall;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .RxD  (RxD),
    .rx_s (rx_s),
    .fall (fall)
  );

  // A line held low after a bad stop bit produces no new edge, so a break never repeats frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (ack && valid)
        valid <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == CNT_MID) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            shift[idx] <= rx_s;
            idx        <= idx + 3'd1;
            if (idx == IDX_LAST)
              state <= PARITY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Completion overrides a coincident ack: the new byte stays valid.
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            data       <= shift;
            parity_err <= (even_parity(shift) != par_bit);
            frame_err  <= ~rx_s;
            overrun    <= overrun | (valid & ~ack);
            valid      <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_read_uart.sv
// Self-checking bench for read_uart: vector table, directed corner cases, random frames.
module tb_read_uart;

  localparam int FREQ = 347;
  localparam int BIT  = FREQ + 1;
  localparam int HALF = BIT / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RxD = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int testsRun = 0;
  int failures = 0;

  logic [7:0] expData;
  logic       expValid;
  logic       expPerr;
  logic       expFerr;
  logic       expOverrun;

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic [7:0] expD;
    logic       expPe;
    logic       expFe;
  } vec_t;

  vec_t vecs[4];

  read_uart #(.freq(FREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RxD       (RxD),
    .data      (data),
    .valid     (valid),
    .ack       (ack),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model at frame level
  function automatic logic correctParity(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++)
      if (d[i]) ones++;
    return logic'(ones % 2);
  endfunction

  task automatic modelReset();
    expData = 8'h00; expValid = 1'b0; expPerr = 1'b0; expFerr = 1'b0; expOverrun = 1'b0;
  endtask

  task automatic modelComplete(input logic [7:0] d, input logic par, input logic stop, input logic ackSame);
    if (expValid && !ackSame)
      expOverrun = 1'b1;
    expValid = 1'b1;
    expData  = d;
    expPerr  = (correctParity(d) != par);
    expFerr  = !stop;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, " data"}, 32'(data), 32'(expData));
    checkOutput({tag, " valid"}, 32'(valid), 32'(expValid));
    checkOutput({tag, " parity_err"}, 32'(parity_err), 32'(expPerr));
    checkOutput({tag, " frame_err"}, 32'(frame_err), 32'(expFerr));
    checkOutput({tag, " overrun"}, 32'(overrun), 32'(expOverrun));
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic par, input logic stop);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      RxD = bits[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic par, input logic stop, input string tag);
    sendFrame(d, par, stop);
    modelComplete(d, par, stop, 1'b0);
    RxD = 1'b1;
    repeat (stop ? 20 : BIT) @(negedge clk);
    checkAll(tag);
  endtask

  task automatic doAck(input string tag);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    if (expValid)
      expValid = 1'b0;
    checkOutput({tag, " valid after ack"}, 32'(valid), 32'(expValid));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    int lat;
    logic got;
    logic [7:0] rd;
    logic rp;
    logic rs;

    vecs[0] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[2] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1};

    modelReset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkAll("reset");

    // 0xA5: exact latency from the pin edge, then ack
    lat = 0;
    got = 1'b0;
    fork
      sendFrame(8'hA5, 1'b0, 1'b1);
      begin
        while (!got && lat < 12 * BIT) begin
          @(negedge clk);
          lat++;
          if (valid) got = 1'b1;
        end
      end
    join
    checkOutput("A5 latency", 32'(lat), 32'(3 + HALF + 10 * BIT));
    modelComplete(8'hA5, 1'b0, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    checkAll("A5");
    doAck("A5");
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checkOutput("ack while idle", 32'(valid), 32'd0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].d, vecs[i].par, vecs[i].stop, $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d table data", i), 32'(data), 32'(vecs[i].expD));
      checkOutput($sformatf("vec%0d table perr", i), 32'(parity_err), 32'(vecs[i].expPe));
      checkOutput($sformatf("vec%0d table ferr", i), 32'(frame_err), 32'(vecs[i].expFe));
      doAck($sformatf("vec%0d", i));
    end

    // Break: bad stop bit, line held low two more bit periods
    sendFrame(8'h3C, 1'b0, 1'b0);
    modelComplete(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    RxD = 1'b1;
    repeat (BIT) @(negedge clk);
    checkAll("break");
    checkOutput("break ferr", 32'(frame_err), 32'd1);
    doAck("break");
    applyStimulus(8'h55, 1'b0, 1'b1, "after break");
    doAck("after break");

    // Glitch shorter than half a bit
    RxD = 1'b0;
    repeat (50) @(negedge clk);
    checkOutput("glitch busy", 32'(busy), 32'd1);
    repeat (50) @(negedge clk);
    RxD = 1'b1;
    repeat (80) @(negedge clk);
    checkOutput("glitch idle", 32'(busy), 32'd0);
    checkOutput("glitch no valid", 32'(valid), 32'd0);
    applyStimulus(8'h7E, 1'b0, 1'b1, "after glitch");
    doAck("after glitch");

    // Back-to-back without ack
    sendFrame(8'h11, 1'b0, 1'b1);
    modelComplete(8'h11, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b0, 1'b1, "b2b");
    checkOutput("b2b overrun", 32'(overrun), 32'd1);

    // Back-to-back with ack coinciding with the second completion
    doReset();
    sendFrame(8'h11, 1'b0, 1'b1);
    modelComplete(8'h11, 1'b0, 1'b1, 1'b0);
    fork
      sendFrame(8'h22, 1'b0, 1'b1);
      begin
        repeat (2 + HALF + 10 * BIT) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
    join
    modelComplete(8'h22, 1'b0, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    checkAll("b2b ack");
    checkOutput("b2b ack overrun", 32'(overrun), 32'd0);
    doAck("b2b ack");

    // Reset in the middle of data bit 4 of 0xFF, then abandon the frame
    RxD = 1'b0;
    repeat (BIT) @(negedge clk);
    RxD = 1'b1;
    repeat (4 * BIT + HALF) @(negedge clk);
    doReset();
    checkAll("mid reset");
    repeat (8 * BIT) @(negedge clk);
    checkOutput("mid reset no valid", 32'(valid), 32'd0);
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    applyStimulus(8'h80, 1'b1, 1'b1, "after reset");
    doAck("after reset");

    for (int i = 0; i < 5; i++) begin
      rd = 8'($urandom_range(0, 255));
      rp = correctParity(rd) ^ ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 3) != 0);
      applyStimulus(rd, rp, rs, $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1)
        doAck($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
